// File: rtl/sram_bit_array.sv
// sram_bit_array
// ---------------------------------------------------------------------------
// A DEPTH x WIDTH static bit-cell array with one write port and one
// registered read port. All state changes on the rising edge of clk.
// Reset is synchronous and active-high.
//
// Reads take exactly one cycle. When a write and a read hit the same word
// on the same edge, the read returns the new data (write-first bypass).
//
// Ports:
//   clk      in   1       sole clock
//   rst      in   1       synchronous active-high reset (clears all words)
//   write    in   1       write enable
//   wr_addr  in   ADDR_W  write word select
//   data     in   WIDTH   write data
//   read     in   1       read enable
//   rd_addr  in   ADDR_W  read word select
//   q        out  WIDTH   read data
//   q_valid  out  1       high when q carries read data
//
// Build option:
//   TRISTATE_OUT_EN  when defined, q floats (all z) whenever q_valid is low,
//                    modelling an undriven pass-gate output. When undefined,
//                    q is driven to all zeros whenever q_valid is low.
// ---------------------------------------------------------------------------
module sram_bit_array #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  data,
  input  logic              read,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  q,
  output logic              q_valid
);

  // Storage cells. With DEPTH == 2**ADDR_W every address value maps to a
  // real word, so addresses wrap modulo DEPTH with no out-of-range case.
  logic [WIDTH-1:0] mem [DEPTH];

  // Registered read data; held at zero whenever no read result is present.
  logic [WIDTH-1:0] q_data;

  // Same-address write and read on one edge: forward the incoming data so
  // the read sees the freshly written value rather than the stale cell.
  logic             bypass;
  logic [WIDTH-1:0] rd_word;

  always_comb begin
    bypass  = write && (wr_addr == rd_addr);
    rd_word = bypass ? data : mem[rd_addr];
  end

  // Storage update. Reset clears every cell and wins over any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write) begin
      mem[wr_addr] <= data;
    end
  end

  // Read port. Reset discards any read presented on the same edge, and an
  // idle cycle returns q_data to zero so no stale word lingers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_data  <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= read;
      q_data  <= read ? rd_word : '0;
    end
  end

`ifdef TRISTATE_OUT_EN
  // Pass gate open only while a result is present; otherwise the line floats.
  assign q = q_valid ? q_data : {WIDTH{1'bz}};
`else
  // q_data is already zero whenever q_valid is low.
  assign q = q_data;
`endif

endmodule

// File: tb/tb_sram_bit_array.sv
// tb_sram_bit_array
// ---------------------------------------------------------------------------
// Self-checking bench for sram_bit_array. A word-level reference model
// (plain array plus expected q/q_valid) is updated on every rising edge and
// compared against the DUT on every falling edge. Directed vectors with
// hand-computed literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_sram_bit_array;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              write;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  data;
  logic              read;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  q;
  logic              q_valid;

  int passCount  = 0;
  int checkCount = 0;

  // Value q must show whenever no read result is present.
  logic [WIDTH-1:0] idleQ;
  initial begin
`ifdef TRISTATE_OUT_EN
    idleQ = {WIDTH{1'bz}};
`else
    idleQ = '0;
`endif
  end

  sram_bit_array #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .write   (write),
    .wr_addr (wr_addr),
    .data    (data),
    .read    (read),
    .rd_addr (rd_addr),
    .q       (q),
    .q_valid (q_valid)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the memory is an ordinary array; a write lands before
  // the read is looked up, which is what write-first means at word level.
  logic [WIDTH-1:0] modelMem [DEPTH];
  logic [WIDTH-1:0] expQ;
  logic             expValid;
  bit               modelReady = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
      expQ     = idleQ;
      expValid = 1'b0;
    end else begin
      if (write) modelMem[int'(wr_addr) % DEPTH] = data;
      if (read) begin
        expQ     = modelMem[int'(rd_addr) % DEPTH];
        expValid = 1'b1;
      end else begin
        expQ     = idleQ;
        expValid = 1'b0;
      end
    end
    modelReady = 1;
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (modelReady) begin
      checkCount++;
      if (q_valid === expValid && q === expQ) begin
        passCount++;
      end else begin
        $display("[TB] FAIL model t=%0t: got q=%h q_valid=%b, expected q=%h q_valid=%b",
                 $time, q, q_valid, expQ, expValid);
      end
    end
  end

  // Drive one cycle of inputs, let one rising edge take them, and return on
  // the following falling edge so outputs are stable for checking.
  task automatic applyStimulus(input logic rs, input logic w,
                               input logic [ADDR_W-1:0] wa,
                               input logic [WIDTH-1:0] d,
                               input logic r,
                               input logic [ADDR_W-1:0] ra);
    rst     = rs;
    write   = w;
    wr_addr = wa;
    data    = d;
    read    = r;
    rd_addr = ra;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare the DUT against a hand-computed literal expectation.
  task automatic checkOutput(input string name,
                             input logic [WIDTH-1:0] wantQ,
                             input logic wantValid);
    checkCount++;
    if (q === wantQ && q_valid === wantValid) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got q=%h q_valid=%b, expected q=%h q_valid=%b",
               name, q, q_valid, wantQ, wantValid);
    end
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; wr_addr = '0; data = '0; read = 1'b0; rd_addr = '0;
    #1;

    // Reset for two cycles, with a write and read presented that must be dropped.
    applyStimulus(1, 1, 4'd3, 8'hEE, 1, 4'd3);
    checkOutput("reset_state", idleQ, 1'b0);
    applyStimulus(1, 0, 4'd0, 8'h00, 0, 4'd0);
    checkOutput("reset_state2", idleQ, 1'b0);

    // Read of a never-written word after reset.
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd3);
    checkOutput("read_unwritten_3", 8'h00, 1'b1);

    // Write then read one cycle later.
    applyStimulus(0, 1, 4'd5, 8'hA5, 0, 4'd0);
    checkOutput("idle_after_write", idleQ, 1'b0);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd5);
    checkOutput("read_5", 8'hA5, 1'b1);

    // Idle cycle after a valid read.
    applyStimulus(0, 0, 4'd0, 8'h00, 0, 4'd5);
    checkOutput("idle_after_read", idleQ, 1'b0);

    // Same-address write and read: write-first.
    applyStimulus(0, 1, 4'd2, 8'h11, 0, 4'd0);
    applyStimulus(0, 1, 4'd2, 8'h3C, 1, 4'd2);
    checkOutput("write_first_2", 8'h3C, 1'b1);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd2);
    checkOutput("reread_2", 8'h3C, 1'b1);

    // Different-address write and read on one edge.
    applyStimulus(0, 1, 4'd4, 8'h77, 1, 4'd5);
    checkOutput("concurrent_read_5", 8'hA5, 1'b1);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd4);
    checkOutput("concurrent_write_4", 8'h77, 1'b1);

    // write=0 holds storage regardless of data/wr_addr.
    applyStimulus(0, 1, 4'd7, 8'h42, 0, 4'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 4'd7, 8'hFF, 0, 4'd0);
    applyStimulus(0, 0, 4'd7, 8'hFF, 1, 4'd7);
    checkOutput("hold_7", 8'h42, 1'b1);

    // Fill words with distinct patterns, then back-to-back reads.
    for (int i = 8; i < 16; i++) begin
      applyStimulus(0, 1, ADDR_W'(i), WIDTH'(8'h90 + i), 0, 4'd0);
    end
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd8);
    checkOutput("b2b_8", 8'h98, 1'b1);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd15);
    checkOutput("b2b_15", 8'h9F, 1'b1);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd11);
    checkOutput("b2b_11", 8'h9B, 1'b1);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd7);
    checkOutput("b2b_7", 8'h42, 1'b1);

    // Reset clears a written word; reset wins over a concurrent read.
    applyStimulus(0, 1, 4'd9, 8'h5A, 0, 4'd0);
    applyStimulus(1, 0, 4'd0, 8'h00, 1, 4'd9);
    checkOutput("during_reset", idleQ, 1'b0);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd9);
    checkOutput("read_9_after_reset", 8'h00, 1'b1);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd7);
    checkOutput("read_7_after_reset", 8'h00, 1'b1);

    // Reset asserted mid-read aborts the result.
    applyStimulus(0, 1, 4'd1, 8'hC3, 1, 4'd1);
    checkOutput("write_first_1", 8'hC3, 1'b1);
    applyStimulus(1, 1, 4'd1, 8'h99, 1, 4'd1);
    checkOutput("reset_aborts_read", idleQ, 1'b0);
    applyStimulus(0, 0, 4'd0, 8'h00, 1, 4'd1);
    checkOutput("read_1_after_reset", 8'h00, 1'b1);

    applyStimulus(0, 0, 4'd0, 8'h00, 0, 4'd0);
    checkOutput("final_idle", idleQ, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sram_bit_array.md
SRAM_BIT_ARRAY -- requirements
Module: sram_bit_array

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per word.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning number of words (power of two, >= 2).
REQ-003 The block SHALL have parameter ADDR_W, default 4, meaning address width, equal to log2(DEPTH).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 write  input  1  write enable (storage-cell access gate).
REQ-008 wr_addr  input  ADDR_W  write word select.
REQ-009 data  input  WIDTH  write data.
REQ-010 read  input  1  read enable (output pass gate).
REQ-011 rd_addr  input  ADDR_W  read word select.
REQ-012 q  output  WIDTH  read data.
REQ-013 q_valid  output  1  high when q carries read data.

Function
REQ-014 Storage SHALL be DEPTH x WIDTH bit cells; each cell holds its value indefinitely while not written (static, cross-coupled-inverter behaviour).
REQ-015 On a rising edge with write=1 and rst=0, word[wr_addr] SHALL take data; all other words are unchanged.
REQ-016 With write=0, no word SHALL change, regardless of data or wr_addr.
REQ-017 On a rising edge with read=1 and rst=0, q SHALL register word[rd_addr] and q_valid SHALL register 1; read latency is exactly one cycle.
REQ-018 On a rising edge with read=0 and rst=0, q_valid SHALL register 0 and q SHALL take the idle value defined in Configuration.
REQ-019 Simultaneous write and read of the same address SHALL be write-first: q SHALL return the new data in the same edge (transparent-cell bypass).
REQ-020 Simultaneous write and read of different addresses SHALL both complete in the same cycle with no interaction.
REQ-021 wr_addr and rd_addr SHALL be used modulo DEPTH; no out-of-range state exists.
REQ-022 A read of a never-written word after reset SHALL return all zeros.
REQ-023 Back-to-back reads SHALL return one result per cycle with no bubbles.

Reset
REQ-024 While rst=1 at a rising edge, every word SHALL be cleared to 0, q SHALL be 0 and q_valid SHALL be 0.
REQ-025 rst SHALL take priority over write and read; writes and reads presented during reset are discarded.
REQ-026 Reset asserted mid-operation SHALL abort any pending read result; the first valid read after reset requires read=1 on a cycle with rst=0.

Configuration
REQ-027 Macro TRISTATE_OUT_EN SHALL select the q idle behaviour.
REQ-028 With TRISTATE_OUT_EN defined, q SHALL be high-impedance (all bits z) whenever q_valid=0, including during and after reset, modelling an undriven pass-gate output.
REQ-029 Without TRISTATE_OUT_EN, q SHALL be driven to all zeros whenever q_valid=0.
REQ-030 q_valid behaviour and all storage behaviour SHALL be identical in both builds.

Verification
REQ-031 Reset then read addr 3 -> q=0x00, q_valid=1 one cycle later.
REQ-032 write=1, wr_addr=5, data=0xA5; next cycle read=1, rd_addr=5 -> q=0xA5, q_valid=1 after one edge.
REQ-033 write=1, wr_addr=2, data=0x3C and read=1, rd_addr=2 on the same edge (old value 0x11) -> q=0x3C.
REQ-034 write=0 with data=0xFF, wr_addr=7 for 10 cycles, then read 7 -> q unchanged (previous value, e.g. 0x00).
REQ-035 Write 0x5A to addr 9, assert rst for one cycle, read 9 -> q=0x00; during rst q_valid=0 and q=z (TRISTATE_OUT_EN) or 0x00 (without).
REQ-036 read=0 for one cycle after a valid read -> q_valid=0; q=z with TRISTATE_OUT_EN, 0x00 without.
